// File: rtl/model_tensor_pkg.sv
// rtl/model_tensor_pkg.sv - shared types and constants for the tensor integration feeders
package model_tensor_pkg;

    localparam int DATA_SIZE    = 64;
    localparam int CONTROL_SIZE = 4;

    localparam logic [DATA_SIZE-1:0]    ZERO_DATA    = '0;
    localparam logic [DATA_SIZE-1:0]    ONE_DATA     = DATA_SIZE'(1);
    localparam logic [CONTROL_SIZE-1:0] ZERO_CONTROL = '0;
    localparam logic [CONTROL_SIZE-1:0] ONE_CONTROL  = CONTROL_SIZE'(1);

    typedef enum logic [CONTROL_SIZE-1:0] {
        STARTER = ZERO_CONTROL,
        INPUT   = ONE_CONTROL,
        OUTPUT  = CONTROL_SIZE'(2),
        ENDER   = CONTROL_SIZE'(3)
    } state_t;

endpackage

// File: rtl/model_tensor_integration_feeder_if.sv
// rtl/model_tensor_integration_feeder_if.sv - control, source stream and element output bundle of the feeder
// Signals:
//   start/ready                      tensor start pulse / completion pulse
//   size_i/size_j/length             tensor extents, sampled on start
//   src_valid/src_ready/src_data     flat scalar source stream
//   sink_request                     consumer request level
//   matrix/vector/scalar_enable      per-element strobes
//   data_out                         element value
// master = driver of the feeder (stimulus side), slave = the feeder itself.
interface model_tensor_integration_feeder_if;
    import model_tensor_pkg::*;

    logic                 start;
    logic                 ready;
    logic [DATA_SIZE-1:0] size_i;
    logic [DATA_SIZE-1:0] size_j;
    logic [DATA_SIZE-1:0] length;
    logic                 src_valid;
    logic                 src_ready;
    logic [DATA_SIZE-1:0] src_data;
    logic                 sink_request;
    logic                 matrix_enable;
    logic                 vector_enable;
    logic                 scalar_enable;
    logic [DATA_SIZE-1:0] data_out;

    modport master (
        output start, size_i, size_j, length, src_valid, src_data, sink_request,
        input  ready, src_ready, matrix_enable, vector_enable, scalar_enable, data_out
    );

    modport slave (
        input  start, size_i, size_j, length, src_valid, src_data, sink_request,
        output ready, src_ready, matrix_enable, vector_enable, scalar_enable, data_out
    );

endinterface

// File: rtl/model_tensor_index_counter.sv
// rtl/model_tensor_index_counter.sv - three-level wrapping i/j/t index counter, t innermost
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   clear_i                zero all indices (takes priority over advance_i)
//   advance_i              step to the next element
//   size_i_i/size_j_i      i and j extents
//   length_i               t extent
//   first_vector_o         t == 0
//   first_matrix_o         j == 0 and t == 0
//   last_o                 all three indices at their maximum
module model_tensor_index_counter
    import model_tensor_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 advance_i,
    input  logic [DATA_SIZE-1:0] size_i_i,
    input  logic [DATA_SIZE-1:0] size_j_i,
    input  logic [DATA_SIZE-1:0] length_i,
    output logic                 first_vector_o,
    output logic                 first_matrix_o,
    output logic                 last_o
);

    logic [DATA_SIZE-1:0] i_q;
    logic [DATA_SIZE-1:0] j_q;
    logic [DATA_SIZE-1:0] t_q;

    logic i_max;
    logic j_max;
    logic t_max;

    assign i_max = (i_q == size_i_i - ONE_DATA);
    assign j_max = (j_q == size_j_i - ONE_DATA);
    assign t_max = (t_q == length_i - ONE_DATA);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            i_q <= ZERO_DATA;
            j_q <= ZERO_DATA;
            t_q <= ZERO_DATA;
        end else if (advance_i) begin
            if (t_max) begin
                t_q <= ZERO_DATA;
                if (j_max) begin
                    j_q <= ZERO_DATA;
                    i_q <= i_max ? ZERO_DATA : i_q + ONE_DATA;
                end else begin
                    j_q <= j_q + ONE_DATA;
                end
            end else begin
                t_q <= t_q + ONE_DATA;
            end
        end
    end

    assign first_vector_o = (t_q == ZERO_DATA);
    assign first_matrix_o = (j_q == ZERO_DATA) && (t_q == ZERO_DATA);
    assign last_o         = i_max && j_max && t_max;

endmodule

// File: rtl/model_tensor_integration_feeder.sv
// rtl/model_tensor_integration_feeder.sv - re-emits a flat scalar stream as an I x J x LENGTH tensor
// Ports:
//   clk_i    single rising-edge clock
//   rst_ni   synchronous active-low reset
//   bus      slave side of model_tensor_integration_feeder_if (start/ready, sizes,
//            source stream, sink request, element strobes and data)
// One source element is captured in INPUT, then emitted on the cycle after a
// sink request in OUTPUT. Every output is a register.
module model_tensor_integration_feeder
    import model_tensor_pkg::*;
(
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    model_tensor_integration_feeder_if.slave      bus
);

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] size_i_q, size_i_d;
    logic [DATA_SIZE-1:0] size_j_q, size_j_d;
    logic [DATA_SIZE-1:0] length_q, length_d;
    logic [DATA_SIZE-1:0] hold_q, hold_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 src_ready_q, src_ready_d;
    logic                 ready_q, ready_d;
    logic                 scalar_q, scalar_d;
    logic                 vector_q, vector_d;
    logic                 matrix_q, matrix_d;

    logic                 cnt_clear;
    logic                 cnt_advance;
    logic                 cnt_first_vector;
    logic                 cnt_first_matrix;
    logic                 cnt_last;

    model_tensor_index_counter u_index (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (cnt_clear),
        .advance_i      (cnt_advance),
        .size_i_i       (size_i_q),
        .size_j_i       (size_j_q),
        .length_i       (length_q),
        .first_vector_o (cnt_first_vector),
        .first_matrix_o (cnt_first_matrix),
        .last_o         (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        size_i_d    = size_i_q;
        size_j_d    = size_j_q;
        length_d    = length_q;
        hold_d      = hold_q;
        data_d      = data_q;
        src_ready_d = 1'b0;
        ready_d     = 1'b0;
        scalar_d    = 1'b0;
        vector_d    = 1'b0;
        matrix_d    = 1'b0;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;

        case (state_q)
            STARTER: begin
                if (bus.start) begin
                    size_i_d  = bus.size_i;
                    size_j_d  = bus.size_j;
                    length_d  = bus.length;
                    cnt_clear = 1'b1;
                    // An empty tensor finishes without touching the source.
                    if ((bus.size_i == ZERO_DATA) || (bus.size_j == ZERO_DATA) ||
                        (bus.length == ZERO_DATA)) begin
                        state_d = ENDER;
                    end else begin
                        state_d     = INPUT;
                        src_ready_d = 1'b1;
                    end
                end
            end
            INPUT: begin
                src_ready_d = 1'b1;
                if (bus.src_valid && src_ready_q) begin
                    hold_d      = bus.src_data;
                    src_ready_d = 1'b0;
                    state_d     = OUTPUT;
                end
            end
            OUTPUT: begin
                if (bus.sink_request) begin
                    data_d      = hold_q;
                    scalar_d    = 1'b1;
                    vector_d    = cnt_first_vector;
                    matrix_d    = cnt_first_matrix;
                    cnt_advance = 1'b1;
                    state_d     = cnt_last ? ENDER : INPUT;
                    src_ready_d = !cnt_last;
                end
            end
            ENDER: begin
                ready_d = 1'b1;
                state_d = STARTER;
            end
            default: begin
                state_d = STARTER;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= STARTER;
            size_i_q    <= ZERO_DATA;
            size_j_q    <= ZERO_DATA;
            length_q    <= ZERO_DATA;
            hold_q      <= ZERO_DATA;
            data_q      <= ZERO_DATA;
            src_ready_q <= 1'b0;
            ready_q     <= 1'b0;
            scalar_q    <= 1'b0;
            vector_q    <= 1'b0;
            matrix_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_i_q    <= size_i_d;
            size_j_q    <= size_j_d;
            length_q    <= length_d;
            hold_q      <= hold_d;
            data_q      <= data_d;
            src_ready_q <= src_ready_d;
            ready_q     <= ready_d;
            scalar_q    <= scalar_d;
            vector_q    <= vector_d;
            matrix_q    <= matrix_d;
        end
    end

    assign bus.ready         = ready_q;
    assign bus.src_ready     = src_ready_q;
    assign bus.data_out      = data_q;
    assign bus.scalar_enable = scalar_q;
    assign bus.vector_enable = vector_q;
    assign bus.matrix_enable = matrix_q;

endmodule

// File: tb/tb_model_tensor_integration_feeder.sv
// tb/tb_model_tensor_integration_feeder.sv - scoreboard bench for model_tensor_integration_feeder
module tb_model_tensor_integration_feeder;
    import model_tensor_pkg::*;

    typedef struct packed {
        logic [DATA_SIZE-1:0] data;
        logic                 vec;
        logic                 mat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    model_tensor_integration_feeder_if bus();

    model_tensor_integration_feeder dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   ready_cnt = 0;
    int   elem_cnt  = 0;
    int   req_mode  = 0;
    bit   holding   = 1'b0;

    task automatic check_w(input string name, input logic [DATA_SIZE+1:0] act,
                           input logic [DATA_SIZE+1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic check_i(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input logic [DATA_SIZE-1:0] d, input logic v, input logic m);
        exp_t x;
        x.data = d;
        x.vec  = v;
        x.mat  = m;
        exp_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_b({tag, "_ready"},     bus.ready, 1'b0);
        check_b({tag, "_src_ready"}, bus.src_ready, 1'b0);
        check_b({tag, "_scalar"},    bus.scalar_enable, 1'b0);
        check_b({tag, "_vector"},    bus.vector_enable, 1'b0);
        check_b({tag, "_matrix"},    bus.matrix_enable, 1'b0);
        check_w({tag, "_data_out"},  {bus.data_out, 2'b00}, '0);
    endtask

    task automatic start_tensor(input int si, input int sj, input int len);
        bus.size_i = DATA_SIZE'(si);
        bus.size_j = DATA_SIZE'(sj);
        bus.length = DATA_SIZE'(len);
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        // Latched copies must be used from here on.
        bus.size_i = '1;
        bus.size_j = '1;
        bus.length = '1;
    endtask

    task automatic send(input logic [DATA_SIZE-1:0] v, input bit tog);
        int n    = 0;
        bit done = 1'b0;
        bit ph   = 1'b1;
        bus.src_data = v;
        while (!done && n < 200) begin
            bus.src_valid = tog ? ph : 1'b1;
            ph = !ph;
            @(negedge clk);
            if (bus.src_valid && bus.src_ready) done = 1'b1;
            tick();
            n++;
        end
        bus.src_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: value %0h not accepted, required acceptance within 200 cycles", v);
        end
    endtask

    task automatic wait_ready(input string name, input int target);
        int n = 0;
        while (ready_cnt < target && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_i({name, "_ready_count"}, ready_cnt, target);
        check_i({name, "_queue_empty"}, exp_q.size(), 0);
        repeat (5) tick();
        check_i({name, "_no_extra_ready"}, ready_cnt, target);
    endtask

    // Monitor: pops the scoreboard on every scalar strobe and checks source hold-off.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.scalar_enable) begin
                    elem_cnt++;
                    holding = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_element: got data %0h, required no element", bus.data_out);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check_w("element", {bus.data_out, bus.vector_enable, bus.matrix_enable},
                                {mon_e.data, mon_e.vec, mon_e.mat});
                    end
                end else if (bus.vector_enable || bus.matrix_enable) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stray_strobe: got vec=%b mat=%b, required 0 without scalar",
                             bus.vector_enable, bus.matrix_enable);
                end
                if (holding) check_b("src_ready_while_holding", bus.src_ready, 1'b0);
                if (bus.src_valid && bus.src_ready) holding = 1'b1;
                if (bus.ready) ready_cnt++;
            end else begin
                holding = 1'b0;
            end
        end
    end

    // Sink request generator: 0 = idle, 1 = held high, 2 = toggling.
    initial begin
        bus.sink_request = 1'b0;
        forever begin
            tick();
            case (req_mode)
                0:       bus.sink_request = 1'b0;
                1:       bus.sink_request = 1'b1;
                default: bus.sink_request = !bus.sink_request;
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200000 ns");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.size_i    = '0;
        bus.size_j    = '0;
        bus.length    = '0;
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // 1: I=1,J=1,L=3, request held high
        req_mode = 1;
        push(64'd10, 1'b1, 1'b1);
        push(64'd20, 1'b0, 1'b0);
        push(64'd30, 1'b0, 1'b0);
        start_tensor(1, 1, 3);
        send(64'd10, 1'b0);
        send(64'd20, 1'b0);
        send(64'd30, 1'b0);
        wait_ready("t1", 1);

        // 2: I=2,J=2,L=2, values 1..8
        push(64'd1, 1'b1, 1'b1);
        push(64'd2, 1'b0, 1'b0);
        push(64'd3, 1'b1, 1'b0);
        push(64'd4, 1'b0, 1'b0);
        push(64'd5, 1'b1, 1'b1);
        push(64'd6, 1'b0, 1'b0);
        push(64'd7, 1'b1, 1'b0);
        push(64'd8, 1'b0, 1'b0);
        start_tensor(2, 2, 2);
        for (int k = 1; k <= 8; k++) send(DATA_SIZE'(k), 1'b0);
        wait_ready("t2", 2);

        // 3: degenerate tensor, READY two cycles after START
        bus.size_i = 64'd2;
        bus.size_j = 64'd0;
        bus.length = 64'd4;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        @(negedge clk);
        check_b("t3_ready_plus1", bus.ready, 1'b0);
        check_b("t3_src_ready_plus1", bus.src_ready, 1'b0);
        @(negedge clk);
        check_b("t3_ready_plus2", bus.ready, 1'b1);
        check_b("t3_src_ready_plus2", bus.src_ready, 1'b0);
        @(negedge clk);
        check_b("t3_ready_plus3", bus.ready, 1'b0);
        tick();
        wait_ready("t3", 3);

        // 4: toggling source valid and sink request
        req_mode = 2;
        push(64'hA1, 1'b1, 1'b1);
        push(64'hA2, 1'b0, 1'b0);
        push(64'hA3, 1'b0, 1'b0);
        push(64'hA4, 1'b0, 1'b0);
        start_tensor(1, 1, 4);
        send(64'hA1, 1'b1);
        send(64'hA2, 1'b1);
        send(64'hA3, 1'b1);
        send(64'hA4, 1'b1);
        wait_ready("t4", 4);

        // 5: reset after the second element, then a 1x1x1 tensor
        req_mode = 1;
        push(64'h11, 1'b1, 1'b1);
        push(64'h12, 1'b0, 1'b0);
        start_tensor(1, 2, 3);
        send(64'h11, 1'b0);
        send(64'h12, 1'b0);
        n = 0;
        while (elem_cnt < 17 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_i("t5_elements_before_reset", elem_cnt, 17);
        tick();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("t5_after_reset");
        check_i("t5_queue_after_reset", exp_q.size(), 0);
        tick();
        rst_n = 1'b1;
        tick();
        push(64'h99, 1'b1, 1'b1);
        start_tensor(1, 1, 1);
        send(64'h99, 1'b0);
        wait_ready("t5", 5);

        // 6: second START mid-tensor is ignored
        push(64'h31, 1'b1, 1'b1);
        push(64'h32, 1'b0, 1'b0);
        push(64'h33, 1'b0, 1'b0);
        start_tensor(1, 1, 3);
        send(64'h31, 1'b0);
        start_tensor(4, 4, 4);
        send(64'h32, 1'b0);
        send(64'h33, 1'b0);
        wait_ready("t6", 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
